// File: rtl/z16_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : z16_mem_pkg
//  Brief    : Shared state encoding and width helpers for the Z16 data RAM.
//  Revision : 1.0
// ============================================================================
package z16_mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    // Number of byte lanes in a data word.
    function automatic int lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

    // Index width for a power-of-two depth; never below one bit.
    function automatic int index_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : z16_mem_pkg
`default_nettype wire

// File: rtl/z16_ram_core.sv
`default_nettype none
// ============================================================================
//  Module   : z16_ram_core
//  Brief    : Single-port synchronous array, per-lane write enable and
//             registered read. The array itself carries no reset.
//  Revision : 1.0
// ============================================================================
module z16_ram_core
    import z16_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic                        i_clk,
    input  logic                        i_we,
    input  logic                        i_re,
    input  logic [index_w(DEPTH)-1:0]   i_addr,
    input  logic [lanes(DATA_W)-1:0]    i_be,
    input  logic [DATA_W-1:0]           i_wdata,
    output logic [DATA_W-1:0]           o_rdata
);

    localparam int c_LANES = lanes(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < c_LANES; k++) begin
                if (i_be[k]) begin
                    r_mem[i_addr][k*BYTE_W +: BYTE_W] <= i_wdata[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : z16_ram_core
`default_nettype wire

// File: rtl/z16_data_ram.sv
`default_nettype none
// ============================================================================
//  Module   : z16_data_ram
//  Brief    : Z16 data memory: range decode, req/ready handshake, byte-lane
//             writes, read-valid/error pipeline and a hardware clear sequencer.
//  Revision : 1.0
// ============================================================================
module z16_data_ram
    import z16_mem_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h8000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req,
    output logic                    o_ready,
    input  logic                    i_wen,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [DATA_W/8-1:0]     i_be,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_rvalid,
    output logic                    o_err,
    input  logic                    i_clr
);

    localparam int                  c_LANES = lanes(DATA_W);
    localparam int                  c_IDX_W = index_w(DEPTH);
    localparam logic [ADDR_W:0]     c_LO    = {1'b0, BASE_ADDR};
    // One extra bit so a window ending at the top of the address space fits.
    localparam logic [ADDR_W:0]     c_HI    = c_LO + (ADDR_W+1)'(DEPTH);
    localparam logic [c_IDX_W-1:0]  c_LAST  = c_IDX_W'(DEPTH - 1);

    state_e                 r_state;
    logic [c_IDX_W-1:0]     r_cnt;
    logic                   r_rvalid;
    logic                   r_err;
    logic                   r_zero;

    logic [ADDR_W:0]        w_addr_ext;
    logic                   w_in_range;
    logic [c_IDX_W-1:0]     w_index;
    logic                   w_accept;
    logic                   w_run;

    logic                   w_mem_we;
    logic                   w_mem_re;
    logic [c_IDX_W-1:0]     w_mem_addr;
    logic [c_LANES-1:0]     w_mem_be;
    logic [DATA_W-1:0]      w_mem_wdata;
    logic [DATA_W-1:0]      w_core_q;

    assign w_run      = (r_state == RUN);
    assign w_addr_ext = {1'b0, i_addr};
    assign w_in_range = (w_addr_ext >= c_LO) && (w_addr_ext < c_HI);
    assign w_index    = i_addr[c_IDX_W-1:0] - BASE_ADDR[c_IDX_W-1:0];
    assign w_accept   = i_req & w_run & ~i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    // Counter wraps to zero on the same edge that leaves CLEAR.
                    r_cnt <= r_cnt + c_IDX_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_cnt <= '0;
                    if (i_clr) begin
                        r_state <= CLEAR;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_addr  = w_index;
        w_mem_be    = i_be;
        w_mem_wdata = i_data;
        if (!w_run) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_cnt;
            w_mem_be    = '1;
            w_mem_wdata = '0;
        end else begin
            w_mem_we = w_accept & i_wen & w_in_range;
            w_mem_re = w_accept & ~i_wen & w_in_range;
        end
    end

    z16_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_be    (w_mem_be),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_core_q)
    );

    // r_zero masks the unreset core register: set by reset or an out-of-range
    // read, cleared by an in-range read, untouched by writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_zero   <= 1'b1;
        end else begin
            r_rvalid <= w_accept;
            r_err    <= w_accept & ~w_in_range;
            if (w_accept && !i_wen) begin
                r_zero <= ~w_in_range;
            end
        end
    end

    assign o_ready  = w_run;
    assign o_rvalid = r_rvalid;
    assign o_err    = r_err;
    assign o_data   = r_zero ? '0 : w_core_q;

endmodule : z16_data_ram
`default_nettype wire
